// File: rtl/pcounter_mc.sv
// ---------------------------------------------------------------------------
// pcounter_mc
//   Multi-channel programmable counter. NCH independent WIDTH-bit channels
//   share one clock, a synchronous active-low reset and a global enable.
//   Each channel supports a synchronous load, up/down counting, and
//   free-run / modulo / one-shot / hold modes. Each channel also has a
//   registered one-cycle terminal-count pulse and a sticky one-shot done flag.
//
// Parameters
//   WIDTH   counter width per channel (>= 2)
//   NCH     number of channels (>= 1)
//
// Ports
//   clk_i       clock; all state changes on the rising edge
//   rst_i       synchronous reset, active low; clears every channel
//   en_i        global count enable, gates all channels
//   ch_en_i     per-channel count enable
//   dir_i       per-channel direction: 1 = up, 0 = down
//   mode_i      per-channel mode, channel k at [2k+1:2k]
//               00 free-run, 01 modulo, 10 one-shot, 11 hold
//   load_i      per-channel synchronous load strobe
//   load_val_i  per-channel load value, channel k at [k*WIDTH +: WIDTH]
//   limit_i     per-channel terminal value for modulo/one-shot up-counting
//   cnt_o       registered counter values, channel k at [k*WIDTH +: WIDTH]
//   tc_o        registered terminal-count pulse, one cycle wide
//   done_o      registered sticky one-shot completion flag
// ---------------------------------------------------------------------------
module pcounter_mc #(
  parameter int WIDTH = 6,
  parameter int NCH   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [NCH-1:0]       ch_en_i,
  input  logic [NCH-1:0]       dir_i,
  input  logic [2*NCH-1:0]     mode_i,
  input  logic [NCH-1:0]       load_i,
  input  logic [NCH*WIDTH-1:0] load_val_i,
  input  logic [NCH*WIDTH-1:0] limit_i,
  output logic [NCH*WIDTH-1:0] cnt_o,
  output logic [NCH-1:0]       tc_o,
  output logic [NCH-1:0]       done_o
);

  typedef enum logic [1:0] {
    MODE_FREE    = 2'b00,
    MODE_MODULO  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;

  for (genvar k = 0; k < NCH; k++) begin : g_ch

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] nxt;
    logic             tc;
    logic             done;
    logic             step;
    logic             at_term;
    logic             up;
    mode_t            mode;

    assign mode     = mode_t'(mode_i[2*k +: 2]);
    assign up       = dir_i[k];
    assign limit    = limit_i[k*WIDTH +: WIDTH];
    assign load_val = load_val_i[k*WIDTH +: WIDTH];

    // Decide whether this edge is a counting step, whether the current value
    // is the terminal one, and what the counter moves to. Up-counting in
    // modulo/one-shot treats anything at or above the limit as terminal so a
    // value loaded past the limit still wraps instead of running away.
    always_comb begin
      step    = 1'b0;
      at_term = 1'b0;
      nxt     = cnt;

      step = en_i && ch_en_i[k] && (mode != MODE_HOLD) &&
             !((mode == MODE_ONESHOT) && done);

      if (up) begin
        if (mode == MODE_FREE) at_term = (cnt == ALL_ONES);
        else                   at_term = (cnt >= limit);
      end else begin
        at_term = (cnt == ZERO);
      end

      if (!at_term) begin
        nxt = up ? cnt + 1'b1 : cnt - 1'b1;
      end else begin
        case (mode)
          MODE_FREE:   nxt = up ? ZERO : ALL_ONES;
          MODE_MODULO: nxt = up ? ZERO : limit;
          default:     nxt = cnt;
        endcase
      end
    end

    // Channel state register. Reset beats load, load beats counting; the tc
    // pulse is rewritten every edge so it can never stretch past one cycle.
    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        cnt  <= ZERO;
        tc   <= 1'b0;
        done <= 1'b0;
      end else if (load_i[k]) begin
        cnt  <= load_val;
        tc   <= 1'b0;
        done <= 1'b0;
      end else if (step) begin
        cnt <= nxt;
        tc  <= at_term;
        if (at_term && (mode == MODE_ONESHOT)) done <= 1'b1;
      end else begin
        tc <= 1'b0;
      end
    end

    assign cnt_o[k*WIDTH +: WIDTH] = cnt;
    assign tc_o[k]                 = tc;
    assign done_o[k]               = done;

  end

endmodule

// File: tb/tb_pcounter_mc.sv
// ---------------------------------------------------------------------------
// tb_pcounter_mc
//   Directed self-checking bench for pcounter_mc (WIDTH=6, NCH=4). Inputs are
//   driven 1 time unit after each rising edge and outputs are sampled at the
//   same point, so every value checked is the register state produced by the
//   edge just passed. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pcounter_mc;

  localparam int WIDTH = 6;
  localparam int NCH   = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 en_i;
  logic [NCH-1:0]       ch_en_i;
  logic [NCH-1:0]       dir_i;
  logic [2*NCH-1:0]     mode_i;
  logic [NCH-1:0]       load_i;
  logic [NCH*WIDTH-1:0] load_val_i;
  logic [NCH*WIDTH-1:0] limit_i;
  logic [NCH*WIDTH-1:0] cnt_o;
  logic [NCH-1:0]       tc_o;
  logic [NCH-1:0]       done_o;

  int checks   = 0;
  int failures = 0;
  int tc_seen;

  pcounter_mc #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .ch_en_i    (ch_en_i),
    .dir_i      (dir_i),
    .mode_i     (mode_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .limit_i    (limit_i),
    .cnt_o      (cnt_o),
    .tc_o       (tc_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and land 1 unit past the rising edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [WIDTH-1:0] ch_cnt(input int k);
    return cnt_o[k*WIDTH +: WIDTH];
  endfunction

  initial begin
    rst_i      = 1'b0;
    en_i       = 1'b1;
    ch_en_i    = 4'b0001;
    dir_i      = 4'b1111;
    mode_i     = '0;
    load_i     = '0;
    load_val_i = '0;
    limit_i    = '0;

    // Reset held with enable high
    $display("[TB] reset");
    applyStimulus(2);
    checkOutput("rst_cnt",  cnt_o,  0);
    checkOutput("rst_tc",   tc_o,   0);
    checkOutput("rst_done", done_o, 0);
    rst_i = 1'b1;
    applyStimulus(1);
    checkOutput("rel_cnt1", ch_cnt(0), 1);
    applyStimulus(1);
    checkOutput("rel_cnt2", ch_cnt(0), 2);
    applyStimulus(1);
    checkOutput("rel_cnt3", ch_cnt(0), 3);
    checkOutput("rel_ch1_idle", ch_cnt(1), 0);

    // Free-run up wrap every 64 steps
    $display("[TB] free-run up");
    tc_seen = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1);
      tc_seen += int'(tc_o[0]);
    end
    checkOutput("fr_cnt63", ch_cnt(0), 63);
    checkOutput("fr_no_tc_before", tc_seen, 0);
    applyStimulus(1);
    checkOutput("fr_wrap_cnt", ch_cnt(0), 0);
    checkOutput("fr_wrap_tc",  tc_o, 4'b0001);
    tc_seen = 0;
    for (int i = 0; i < 63; i++) begin
      applyStimulus(1);
      tc_seen += int'(tc_o[0]);
    end
    checkOutput("fr_cnt63_b", ch_cnt(0), 63);
    checkOutput("fr_no_tc_between", tc_seen, 0);
    applyStimulus(1);
    checkOutput("fr_wrap2_cnt", ch_cnt(0), 0);
    checkOutput("fr_wrap2_tc",  tc_o[0], 1);

    // Modulo on ch1, limit 9
    $display("[TB] modulo");
    ch_en_i          = 4'b0010;
    mode_i[3:2]      = 2'b01;
    limit_i[11:6]    = 6'd9;
    load_val_i[11:6] = 6'd0;
    load_i           = 4'b0010;
    applyStimulus(1);
    load_i = '0;
    checkOutput("mod_load0", ch_cnt(1), 0);
    tc_seen = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1);
      tc_seen += int'(tc_o[1]);
    end
    checkOutput("mod_cnt9", ch_cnt(1), 9);
    checkOutput("mod_no_tc", tc_seen, 0);
    checkOutput("mod_ch0_held", ch_cnt(0), 0);
    applyStimulus(1);
    checkOutput("mod_wrap_cnt", ch_cnt(1), 0);
    checkOutput("mod_wrap_tc",  tc_o, 4'b0010);
    applyStimulus(1);
    checkOutput("mod_after_cnt", ch_cnt(1), 1);
    checkOutput("mod_after_tc",  tc_o[1], 0);

    dir_i[1] = 1'b0;
    load_i   = 4'b0010;
    applyStimulus(1);
    load_i = '0;
    checkOutput("moddn_load", ch_cnt(1), 0);
    checkOutput("moddn_load_tc", tc_o[1], 0);
    applyStimulus(1);
    checkOutput("moddn_wrap_cnt", ch_cnt(1), 9);
    checkOutput("moddn_wrap_tc",  tc_o[1], 1);
    applyStimulus(1);
    checkOutput("moddn_cnt8", ch_cnt(1), 8);
    checkOutput("moddn_tc0",  tc_o[1], 0);

    // Value above limit is terminal when counting up
    dir_i[1]         = 1'b1;
    load_val_i[11:6] = 6'd12;
    load_i           = 4'b0010;
    applyStimulus(1);
    load_i = '0;
    checkOutput("mod_over_load", ch_cnt(1), 12);
    applyStimulus(1);
    checkOutput("mod_over_cnt", ch_cnt(1), 0);
    checkOutput("mod_over_tc",  tc_o[1], 1);

    // limit 0: stays at 0 and pulses every enabled cycle
    limit_i[11:6] = 6'd0;
    applyStimulus(1);
    checkOutput("lim0_cnt_a", ch_cnt(1), 0);
    checkOutput("lim0_tc_a",  tc_o[1], 1);
    applyStimulus(1);
    checkOutput("lim0_cnt_b", ch_cnt(1), 0);
    checkOutput("lim0_tc_b",  tc_o[1], 1);

    // One-shot down on ch2 from 5
    $display("[TB] one-shot");
    ch_en_i           = 4'b0100;
    mode_i[5:4]       = 2'b10;
    dir_i[2]          = 1'b0;
    load_val_i[17:12] = 6'd5;
    load_i            = 4'b0100;
    applyStimulus(1);
    load_i = '0;
    checkOutput("os_load5", ch_cnt(2), 5);
    checkOutput("os_done0", done_o[2], 0);
    for (int v = 4; v >= 0; v--) begin
      applyStimulus(1);
      checkOutput("os_step_cnt", ch_cnt(2), v);
      checkOutput("os_step_tc",  tc_o[2], 0);
    end
    applyStimulus(1);
    checkOutput("os_term_cnt",  ch_cnt(2), 0);
    checkOutput("os_term_tc",   tc_o, 4'b0100);
    checkOutput("os_term_done", done_o, 4'b0100);
    tc_seen = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      tc_seen += int'(tc_o[2]);
    end
    checkOutput("os_hold_cnt",  ch_cnt(2), 0);
    checkOutput("os_hold_notc", tc_seen, 0);
    checkOutput("os_hold_done", done_o[2], 1);
    mode_i[5:4] = 2'b11;
    applyStimulus(1);
    checkOutput("os_modechg_done", done_o[2], 1);
    mode_i[5:4]       = 2'b10;
    load_val_i[17:12] = 6'd3;
    load_i            = 4'b0100;
    applyStimulus(1);
    load_i = '0;
    checkOutput("os_reload_cnt",  ch_cnt(2), 3);
    checkOutput("os_reload_done", done_o[2], 0);
    applyStimulus(1);
    checkOutput("os_resume_cnt", ch_cnt(2), 2);

    // Enable gating on ch0
    $display("[TB] enable gating");
    ch_en_i = 4'b0001;
    applyStimulus(2);
    checkOutput("gate_start", ch_cnt(0), 2);
    en_i    = 1'b0;
    tc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      tc_seen += int'(tc_o != 0);
    end
    checkOutput("gate_en_hold", ch_cnt(0), 2);
    checkOutput("gate_en_notc", tc_seen, 0);
    load_val_i[5:0] = 6'd62;
    load_i          = 4'b0001;
    applyStimulus(1);
    load_i = '0;
    checkOutput("gate_load", ch_cnt(0), 62);
    en_i = 1'b1;
    applyStimulus(1);
    checkOutput("gate_cnt63", ch_cnt(0), 63);
    ch_en_i = 4'b0000;
    tc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      tc_seen += int'(tc_o != 0);
    end
    checkOutput("gate_chen_hold", ch_cnt(0), 63);
    checkOutput("gate_chen_notc", tc_seen, 0);
    ch_en_i = 4'b0001;
    applyStimulus(1);
    checkOutput("gate_resume_cnt", ch_cnt(0), 0);
    checkOutput("gate_resume_tc",  tc_o[0], 1);

    // Reset beats load; simultaneous terminals on ch0 and ch3
    $display("[TB] reset vs load, simultaneity");
    rst_i      = 1'b0;
    load_val_i = {NCH{6'd7}};
    load_i     = 4'b1111;
    applyStimulus(1);
    checkOutput("rstld_cnt",  cnt_o,  0);
    checkOutput("rstld_tc",   tc_o,   0);
    checkOutput("rstld_done", done_o, 0);
    rst_i             = 1'b1;
    mode_i[1:0]       = 2'b00;
    mode_i[7:6]       = 2'b01;
    dir_i[0]          = 1'b1;
    dir_i[3]          = 1'b1;
    limit_i[23:18]    = 6'd5;
    load_val_i[5:0]   = 6'd62;
    load_val_i[23:18] = 6'd4;
    load_i            = 4'b1001;
    ch_en_i           = 4'b1001;
    applyStimulus(1);
    load_i = '0;
    checkOutput("sim_load_ch0", ch_cnt(0), 62);
    checkOutput("sim_load_ch3", ch_cnt(3), 4);
    applyStimulus(1);
    checkOutput("sim_pre_ch0", ch_cnt(0), 63);
    checkOutput("sim_pre_ch3", ch_cnt(3), 5);
    checkOutput("sim_pre_tc",  tc_o, 0);
    applyStimulus(1);
    checkOutput("sim_wrap_ch0", ch_cnt(0), 0);
    checkOutput("sim_wrap_ch3", ch_cnt(3), 0);
    checkOutput("sim_wrap_tc",  tc_o, 4'b1001);
    applyStimulus(1);
    checkOutput("sim_next_ch0", ch_cnt(0), 1);
    checkOutput("sim_next_ch3", ch_cnt(3), 1);
    checkOutput("sim_next_tc",  tc_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
